// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, error codes,
// and the table index width helper (never narrower than one bit).
package mem_check_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} chk_state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_MISMATCH, ERR_EXTRA, ERR_TIMEOUT} chk_err_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Core data-memory write port as seen by the checker.
// The core side drives it; the checker only observes.
interface mem_wr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker_exp_match_table.sv
// Expected-write table with per-entry hit bits; combinational lookup of the
// current write (full match index/valid and address-only match).
module exp_match_table
  import mem_check_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int ORDERED = 1,
  parameter int IDX_W   = idx_width(N_EXP),
  parameter int CNT_W   = $clog2(N_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [ADDR_W-1:0] load_adr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              hit_clr,
  input  logic              hit_set,
  input  logic [IDX_W-1:0]  hit_idx,
  input  logic [CNT_W-1:0]  ptr,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full_vld,
  output logic [IDX_W-1:0]  full_idx,
  output logic              adr_vld
);

  logic [ADDR_W-1:0] tbl_adr  [N_EXP];
  logic [DATA_W-1:0] tbl_data [N_EXP];
  logic [N_EXP-1:0]  hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit <= '0;
      for (int i = 0; i < N_EXP; i++) begin
        tbl_adr[i]  <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_EXP; i++) begin
        if (load && load_idx == IDX_W'(i)) begin
          tbl_adr[i]  <= load_adr;
          tbl_data[i] <= load_data;
        end
        if (hit_clr) begin
          hit[i] <= 1'b0;
        end else if (hit_set && hit_idx == IDX_W'(i)) begin
          hit[i] <= 1'b1;
        end
      end
    end
  end

  // Ordered mode only ever looks at the entry under the match pointer; unordered
  // mode considers every unhit entry. Scanning downwards leaves the lowest index.
  always_comb begin
    full_vld = 1'b0;
    full_idx = '0;
    adr_vld  = 1'b0;
    for (int i = N_EXP - 1; i >= 0; i--) begin
      if (((ORDERED != 0) ? (ptr == CNT_W'(i)) : !hit[i]) && tbl_adr[i] == wr_adr) begin
        adr_vld = 1'b1;
        if (tbl_data[i] == wr_data) begin
          full_vld = 1'b1;
          full_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Checks sampled core data-memory writes against a table of expected writes;
// verdict flags and counters are registered, visible the cycle after the deciding write.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_EXP       = 4,
  parameter int ORDERED     = 1,
  parameter int ALLOW_EXTRA = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           exp_load,
  input  logic [idx_width(N_EXP)-1:0]    exp_idx,
  input  logic [ADDR_W-1:0]              exp_adr,
  input  logic [DATA_W-1:0]              exp_data,
  input  logic                           start,
  mem_wr_if.slave                        wr,
  output logic                           armed,
  output logic                           done,
  output logic                           pass,
  output logic                           fail,
  output logic [1:0]                     err_code,
  output logic [$clog2(N_EXP+1)-1:0]     match_cnt,
  output logic [15:0]                    write_cnt,
  output logic [ADDR_W-1:0]              fail_adr
);

  localparam int IDX_W = idx_width(N_EXP);
  localparam int CNT_W = $clog2(N_EXP + 1);

  chk_state_t       state;
  logic [31:0]      tmo_cnt;
  logic             full_vld;
  logic             adr_vld;
  logic [IDX_W-1:0] full_idx;
  logic             sampled;
  logic             hit_set;
  logic             arm_now;
  logic             final_hit;

  assign sampled   = (state == ARMED) && wr.mem_write;
  assign hit_set   = sampled && full_vld;
  assign arm_now   = start && (state != ARMED);
  assign final_hit = hit_set && (match_cnt == CNT_W'(N_EXP - 1));

  exp_match_table #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_EXP   (N_EXP),
    .ORDERED (ORDERED),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_tbl (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (exp_load && (state == IDLE)),
    .load_idx  (exp_idx),
    .load_adr  (exp_adr),
    .load_data (exp_data),
    .hit_clr   (arm_now),
    .hit_set   (hit_set),
    .hit_idx   (full_idx),
    .ptr       (match_cnt),
    .wr_adr    (wr.data_adr),
    .wr_data   (wr.write_data),
    .full_vld  (full_vld),
    .full_idx  (full_idx),
    .adr_vld   (adr_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_code  <= ERR_NONE;
      match_cnt <= '0;
      write_cnt <= '0;
      fail_adr  <= '0;
      tmo_cnt   <= '0;
    end else if (arm_now) begin
      state     <= ARMED;
      armed     <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      err_code  <= ERR_NONE;
      match_cnt <= '0;
      write_cnt <= '0;
      fail_adr  <= '0;
      tmo_cnt   <= '0;
    end else if (state == ARMED) begin
      if (sampled && write_cnt != 16'hFFFF) begin
        write_cnt <= write_cnt + 16'd1;
      end
      if (hit_set) begin
        match_cnt <= match_cnt + 1'b1;
      end
      // A completing match outranks a timeout landing on the same edge.
      if (final_hit) begin
        state <= PASS;
        armed <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b1;
      end else if (sampled && !full_vld && (adr_vld || ALLOW_EXTRA == 0)) begin
        state    <= FAIL;
        armed    <= 1'b0;
        done     <= 1'b1;
        fail     <= 1'b1;
        err_code <= adr_vld ? ERR_MISMATCH : ERR_EXTRA;
        fail_adr <= wr.data_adr;
      end else if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
        state    <= FAIL;
        armed    <= 1'b0;
        done     <= 1'b1;
        fail     <= 1'b1;
        err_code <= ERR_TIMEOUT;
        fail_adr <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: four differently-configured instances share one
// stimulus bus; directed scenarios plus randomized runs against a table model.
module tb_mem_write_checker;

  localparam int NDUT = 4;
  localparam int P_N   [NDUT] = '{1, 4, 2, 3};
  localparam int P_ORD [NDUT] = '{1, 1, 0, 0};
  localparam int P_EXT [NDUT] = '{0, 0, 1, 0};
  localparam int P_TO  [NDUT] = '{1000, 20, 1000, 40};

  typedef struct packed {
    logic        armed;
    logic        done;
    logic        pass;
    logic        fail;
    logic [1:0]  err;
    logic [3:0]  mc;
    logic [15:0] wc;
    logic [31:0] fa;
  } snap_t;

  logic        clk;
  logic        reset_n;
  logic        exp_load;
  logic [1:0]  exp_idx;
  logic [31:0] exp_adr;
  logic [31:0] exp_data;
  logic [3:0]  start_v;

  logic        armed_w [NDUT];
  logic        done_w  [NDUT];
  logic        pass_w  [NDUT];
  logic        fail_w  [NDUT];
  logic [1:0]  err_w   [NDUT];
  logic [3:0]  mcnt_w  [NDUT];
  logic [15:0] wcnt_w  [NDUT];
  logic [31:0] fadr_w  [NDUT];

  mem_wr_if #(.ADDR_W(32), .DATA_W(32)) wr ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int IW = mem_check_pkg::idx_width(P_N[g]);
    localparam int CW = $clog2(P_N[g] + 1);
    logic [CW-1:0] mc;
    mem_write_checker #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .N_EXP       (P_N[g]),
      .ORDERED     (P_ORD[g]),
      .ALLOW_EXTRA (P_EXT[g]),
      .TIMEOUT_CYC (P_TO[g])
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .exp_load   (exp_load),
      .exp_idx    (exp_idx[IW-1:0]),
      .exp_adr    (exp_adr),
      .exp_data   (exp_data),
      .start      (start_v[g]),
      .wr         (wr),
      .armed      (armed_w[g]),
      .done       (done_w[g]),
      .pass       (pass_w[g]),
      .fail       (fail_w[g]),
      .err_code   (err_w[g]),
      .match_cnt  (mc),
      .write_cnt  (wcnt_w[g]),
      .fail_adr   (fadr_w[g])
    );
    assign mcnt_w[g] = 4'(mc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    sel    = 0;
  snap_t o;
  snap_t e;

  // Reference model state: expected table, consumed entries, verdict.
  int          m_tbl_a [4];
  int          m_tbl_d [4];
  bit          m_used  [4];
  bit          m_armed;
  bit          m_pass;
  bit          m_fail;
  int          m_err;
  int          m_match;
  int          m_wcnt;
  int          m_edges;
  logic [31:0] m_fadr;

  function automatic snap_t obs();
    snap_t s;
    s.armed = armed_w[sel];
    s.done  = done_w[sel];
    s.pass  = pass_w[sel];
    s.fail  = fail_w[sel];
    s.err   = err_w[sel];
    s.mc    = mcnt_w[sel];
    s.wc    = wcnt_w[sel];
    s.fa    = fadr_w[sel];
    return s;
  endfunction

  function automatic snap_t mk(input bit a, input bit d, input bit p, input bit f,
                               input int er, input int mc, input int wc, input logic [31:0] fa);
    snap_t s;
    s.armed = a;
    s.done  = d;
    s.pass  = p;
    s.fail  = f;
    s.err   = 2'(er);
    s.mc    = 4'(mc);
    s.wc    = 16'(wc);
    s.fa    = fa;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("arm=%0b done=%0b pass=%0b fail=%0b err=%0d mc=%0d wc=%0d fa=%h",
                     s.armed, s.done, s.pass, s.fail, s.err, s.mc, s.wc, s.fa);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int a, input int d);
    wr.mem_write  = 1'b1;
    wr.data_adr   = 32'(a);
    wr.write_data = 32'(d);
    tick();
    wr.mem_write  = 1'b0;
  endtask

  task automatic load(input int idx, input int a, input int d);
    exp_load = 1'b1;
    exp_idx  = 2'(idx);
    exp_adr  = 32'(a);
    exp_data = 32'(d);
    tick();
    exp_load = 1'b0;
  endtask

  task automatic arm();
    start_v[sel] = 1'b1;
    tick();
    start_v = '0;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic model_arm();
    m_armed = 1; m_pass = 0; m_fail = 0; m_err = 0;
    m_match = 0; m_wcnt = 0; m_edges = 0; m_fadr = '0;
    for (int i = 0; i < 4; i++) m_used[i] = 0;
  endtask

  // One clock edge as seen by the checker; res 0 = match, 1 = wrong data, 2 = stray write.
  task automatic model_edge(input bit we, input int a, input int d);
    int k;
    int res;
    if (!m_armed) return;
    m_edges++;
    if (we) begin
      if (m_wcnt < 65535) m_wcnt++;
      k = -1;
      res = 2;
      if (P_ORD[sel] != 0) begin
        if (m_tbl_a[m_match] == a) begin
          res = (m_tbl_d[m_match] == d) ? 0 : 1;
          k = m_match;
        end
      end else begin
        for (int i = 0; i < P_N[sel]; i++)
          if (k < 0 && !m_used[i] && m_tbl_a[i] == a && m_tbl_d[i] == d) k = i;
        if (k >= 0) res = 0;
        else for (int i = 0; i < P_N[sel]; i++)
          if (!m_used[i] && m_tbl_a[i] == a) res = 1;
      end
      if (res == 0) begin
        m_used[k] = 1;
        m_match++;
        if (m_match == P_N[sel]) begin m_armed = 0; m_pass = 1; end
      end else if (res == 1 || P_EXT[sel] == 0) begin
        m_armed = 0; m_fail = 1; m_err = res; m_fadr = 32'(a);
      end
    end
    if (m_armed && m_edges == P_TO[sel]) begin
      m_armed = 0; m_fail = 1; m_err = 3; m_fadr = '0;
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < NDUT; s++) begin
      sel = s;
      o = obs(); e = mk(0, 0, 0, 0, 0, 0, 0, 0); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_state[%0d]: got %s want %s", s, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_basic_pass();
    sel = 0;
    hard_reset();
    load(0, 'h64, 7);
    arm();
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL basic_armed: got %s want %s", fmt(o), fmt(e)); end
    repeat (9) tick();
    drive_write('h64, 7);
    o = obs(); e = mk(0, 1, 1, 0, 0, 1, 1, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL basic_pass: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_load_start_same_cycle();
    sel = 0;
    hard_reset();
    exp_load = 1'b1; exp_idx = 2'd0; exp_adr = 'h70; exp_data = 9; start_v[0] = 1'b1;
    tick();
    exp_load = 1'b0; start_v = '0;
    load(0, 'h74, 1);
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL load_start_armed: got %s want %s", fmt(o), fmt(e)); end
    drive_write('h70, 9);
    o = obs(); e = mk(0, 1, 1, 0, 0, 1, 1, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL load_start_pass: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic load_b_table();
    load(0, 'h60, 5);
    load(1, 'h64, 7);
    load(2, 'h68, 1);
    load(3, 'h6C, 2);
  endtask

  task automatic test_ordered_mismatch();
    sel = 1;
    hard_reset();
    load_b_table();
    arm();
    drive_write('h60, 5);
    o = obs(); e = mk(1, 0, 0, 0, 0, 1, 1, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL ord_first: got %s want %s", fmt(o), fmt(e)); end
    arm();
    o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL start_while_armed: got %s want %s", fmt(o), fmt(e)); end
    drive_write('h64, 8);
    o = obs(); e = mk(0, 1, 0, 1, 1, 1, 2, 'h64); checks++;
    if (o !== e) begin errors++; $display("FAIL ord_mismatch: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_extra_disallowed();
    sel = 1;
    hard_reset();
    load_b_table();
    arm();
    drive_write('h44, 3);
    o = obs(); e = mk(0, 1, 0, 1, 2, 0, 1, 'h44); checks++;
    if (o !== e) begin errors++; $display("FAIL extra_disallowed: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_timeout_tie();
    sel = 1;
    hard_reset();
    load_b_table();
    arm();
    repeat (19) tick();
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL tmo_edge19: got %s want %s", fmt(o), fmt(e)); end
    tick();
    o = obs(); e = mk(0, 1, 0, 1, 3, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL tmo_fail: got %s want %s", fmt(o), fmt(e)); end
    for (int last = 19; last <= 20; last++) begin
      arm();
      drive_write('h60, 5);
      drive_write('h64, 7);
      drive_write('h68, 1);
      repeat (last - 4) tick();
      drive_write('h6C, 2);
      o = obs(); e = mk(0, 1, 1, 0, 0, 4, 4, 0); checks++;
      if (o !== e) begin errors++; $display("FAIL tie_edge%0d: got %s want %s", last, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back_unordered();
    sel = 2;
    hard_reset();
    load(0, 'h10, 1);
    load(1, 'h20, 2);
    arm();
    drive_write('h30, 9);
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL unord_extra_ignored: got %s want %s", fmt(o), fmt(e)); end
    drive_write('h20, 2);
    drive_write('h20, 2);
    o = obs(); e = mk(1, 0, 0, 0, 0, 1, 3, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL unord_repeat_ignored: got %s want %s", fmt(o), fmt(e)); end
    drive_write('h10, 1);
    o = obs(); e = mk(0, 1, 1, 0, 0, 2, 4, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL unord_pass: got %s want %s", fmt(o), fmt(e)); end
    arm();
    drive_write('h10, 7);
    o = obs(); e = mk(0, 1, 0, 1, 1, 0, 1, 'h10); checks++;
    if (o !== e) begin errors++; $display("FAIL unord_mismatch: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_duplicates();
    sel = 3;
    hard_reset();
    load(0, 'h10, 1);
    load(1, 'h10, 1);
    load(2, 'h20, 2);
    arm();
    drive_write('h10, 1);
    drive_write('h10, 5);
    o = obs(); e = mk(0, 1, 0, 1, 1, 1, 2, 'h10); checks++;
    if (o !== e) begin errors++; $display("FAIL dup_mismatch: got %s want %s", fmt(o), fmt(e)); end
    arm();
    drive_write('h10, 1);
    drive_write('h10, 1);
    drive_write('h10, 1);
    o = obs(); e = mk(0, 1, 0, 1, 2, 2, 3, 'h10); checks++;
    if (o !== e) begin errors++; $display("FAIL dup_repeat_extra: got %s want %s", fmt(o), fmt(e)); end
    arm();
    drive_write('h20, 2);
    drive_write('h10, 1);
    drive_write('h10, 1);
    o = obs(); e = mk(0, 1, 1, 0, 0, 3, 3, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL dup_pass: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_rearm_reset();
    sel = 0;
    hard_reset();
    load(0, 'h64, 7);
    arm();
    drive_write('h64, 7);
    arm();
    o = obs(); e = mk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL rearm_cleared: got %s want %s", fmt(o), fmt(e)); end
    drive_write('h64, 7);
    o = obs(); e = mk(0, 1, 1, 0, 0, 1, 1, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL rearm_pass: got %s want %s", fmt(o), fmt(e)); end
    arm();
    tick();
    reset_n = 1'b0;
    #2;
    o = obs(); e = mk(0, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %s want %s", fmt(o), fmt(e)); end
    reset_n = 1'b1;
    tick();
    o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL post_reset_idle: got %s want %s", fmt(o), fmt(e)); end
    arm();
    drive_write('h64, 7);
    o = obs(); e = mk(0, 1, 0, 1, 2, 0, 1, 'h64); checks++;
    if (o !== e) begin errors++; $display("FAIL table_cleared: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_random();
    int r, idx, a, d;
    bit we;
    for (int s = 1; s < NDUT; s++) begin
      sel = s;
      repeat (12) begin
        hard_reset();
        for (int i = 0; i < P_N[s]; i++) begin
          m_tbl_a[i] = 'h100 + 4 * int'($urandom_range(0, 2));
          m_tbl_d[i] = int'($urandom_range(0, 2));
          load(i, m_tbl_a[i], m_tbl_d[i]);
        end
        arm();
        model_arm();
        for (int cyc = 0; cyc < 60 && m_armed; cyc++) begin
          r  = int'($urandom_range(0, 9));
          we = (r >= 3);
          a  = 'h100 + 4 * int'($urandom_range(0, 3));
          d  = int'($urandom_range(0, 2));
          if (r >= 3 && r <= 6) begin
            idx = (P_ORD[s] != 0) ? m_match : int'($urandom_range(0, P_N[s] - 1));
            a = m_tbl_a[idx];
            d = (r == 6) ? int'($urandom_range(0, 2)) : m_tbl_d[idx];
          end
          wr.mem_write  = we;
          wr.data_adr   = 32'(a);
          wr.write_data = 32'(d);
          start_v[s]    = ($urandom_range(0, 15) == 0);
          exp_load      = ($urandom_range(0, 15) == 0);
          exp_idx       = 2'($urandom_range(0, 3));
          exp_adr       = 32'(a);
          exp_data      = 32'(d + 1);
          tick();
          model_edge(we, a, d);
          wr.mem_write = 1'b0; start_v = '0; exp_load = 1'b0;
          o = obs();
          e = mk(m_armed, m_pass | m_fail, m_pass, m_fail, m_err, m_match, m_wcnt, m_fadr);
          checks++;
          if (o !== e) begin errors++; $display("FAIL rand[%0d] cyc %0d: got %s want %s", s, cyc, fmt(o), fmt(e)); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b1;
    exp_load      = 1'b0;
    exp_idx       = '0;
    exp_adr       = '0;
    exp_data      = '0;
    start_v       = '0;
    wr.mem_write  = 1'b0;
    wr.data_adr   = '0;
    wr.write_data = '0;
    #2;
    reset_n = 1'b0;
    #2;
    test_reset();
    test_basic_pass();
    test_load_start_same_cycle();
    test_ordered_mismatch();
    test_extra_disallowed();
    test_timeout_tie();
    test_back_to_back_unordered();
    test_duplicates();
    test_rearm_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-checking monitor on the CPU data-memory write port (clk, mem_write, data_adr, write_data) of the single-cycle core's top.
- Holds a table of N_EXP expected (address, data) writes and checks every sampled write against it, ordered or unordered.
- Raises pass, or fail with an error code and a timeout.
- Replaces the fixed "7 written to 0x64" end-of-program check with a reusable block usable in the bench and on the FPGA.

Parameters:
- ADDR_W, 32, width of data_adr and exp_adr
- DATA_W, 32, width of write_data and exp_data
- N_EXP, 4, number of expected-write table entries (1..16)
- ORDERED, 1, 1 = writes must match entries 0..N_EXP-1 in sequence; 0 = any order
- ALLOW_EXTRA, 0, 1 = non-matching writes are counted and ignored; 0 = non-matching write is a failure
- TIMEOUT_CYC, 1000, cycles allowed in ARMED before timeout failure (>=1)

Ports:
- clk  in  1  rising-edge clock, same as the core
- reset_n  in  1  asynchronous active-low reset
- exp_load  in  1  write exp_adr/exp_data into table entry exp_idx (accepted in IDLE only)
- exp_idx  in  $clog2(N_EXP)  table index
- exp_adr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- start  in  1  arm checker (IDLE only)
- mem_write  in  1  core data-memory write enable
- data_adr  in  ADDR_W  core write address
- write_data  in  DATA_W  core write data
- armed  out  1  state == ARMED
- done  out  1  state is PASS or FAIL
- pass  out  1  state == PASS
- fail  out  1  state == FAIL
- err_code  out  2  0 none, 1 mismatch, 2 unexpected extra write, 3 timeout
- match_cnt  out  $clog2(N_EXP+1)  entries matched
- write_cnt  out  16  writes sampled while ARMED, saturating at 16'hFFFF
- fail_adr  out  ADDR_W  address of the offending write (0 on timeout)

Behaviour:
- Reset (async assert, sync-to-clk release): state IDLE, all outputs 0, hit bits 0, table contents 0.
- Sampling: on each rising edge in ARMED with mem_write=1, exactly one write is sampled. All outputs are registered; a verdict is visible the cycle after the deciding write.
- FSM:
  - IDLE -> ARMED on start. Clears counters, hit bits, err_code, fail_adr and the timeout counter.
  - ARMED -> PASS when match_cnt reaches N_EXP (the cycle after the last match).
  - ARMED -> FAIL on mismatch, on a disallowed extra write, or when the timeout counter reaches TIMEOUT_CYC-1 with no verdict.
  - PASS/FAIL -> IDLE only on start=1, which re-arms directly to ARMED and clears as above. The table is retained.
  - Reset mid-ARMED: immediate return to IDLE, verdict lost.
- ORDERED=1:
  - A write equal to entry[match_cnt] (both address and data) increments match_cnt.
  - Address equal but data different: FAIL, err_code 1.
  - Address not equal: FAIL, err_code 2 when ALLOW_EXTRA=0; otherwise ignored.
- ORDERED=0:
  - Matching is checked against all entries with hit=0. The lowest-index full match sets its hit bit and increments match_cnt.
  - Address matches an unhit entry but data differs: err_code 1.
  - No address match, or a repeat of an already-hit entry: handled as an extra write (err_code 2, or ignored when ALLOW_EXTRA=1).
  - Duplicate table entries are legal; each needs its own write.
- Simultaneous events:
  - Final matching write and timeout on the same cycle: PASS wins.
  - exp_load and start on the same cycle: the load is applied first, then the checker arms.
  - exp_load outside IDLE is ignored.
  - start while ARMED is ignored.
- write_cnt counts all sampled writes, matched or not.
- fail_adr captures data_adr of the failing write.

Decomposition:
- Package mem_check_pkg holds:
  - typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} chk_state_t
  - typedef enum logic [1:0] {ERR_NONE, ERR_MISMATCH, ERR_EXTRA, ERR_TIMEOUT} chk_err_t
- One natural sub-module, exp_match_table: stores the N_EXP entries and hit bits, and gives combinational results (full-match index/valid, address-only-match valid) for the current write.
- The FSM, counters and timeout logic stay in mem_write_checker.

Test Plan:
- Basic pass: N_EXP=1, entry0 = (0x64, 7); start; core writes 7 to 0x64 at cycle 10 -> pass=1 on cycle 11, match_cnt=1, err_code=0.
- Ordered mismatch: entries (0x60, 5), (0x64, 7); write (0x60, 5) then (0x64, 8) -> fail=1, err_code=1, fail_adr=0x64, match_cnt=1.
- Unordered plus extra allowed: ORDERED=0, ALLOW_EXTRA=1, entries (0x10, 1), (0x20, 2); writes (0x30, 9), (0x20, 2), (0x10, 1) -> pass, write_cnt=3, match_cnt=2.
- Extra disallowed: ORDERED=1, ALLOW_EXTRA=0; write (0x44, 3) before any match -> fail, err_code=2, fail_adr=0x44.
- Timeout and tie: TIMEOUT_CYC=20 with no writes -> fail, err_code=3 exactly 20 cycles after arming. Repeat with the final match landing on cycle 19 -> pass.
- Reset and re-arm: deassert reset_n mid-ARMED -> all outputs 0 asynchronously. Then start after a PASS -> armed=1, counters 0, table retained, and the same writes pass again.
